// File: rtl/sram_responder_pkg.sv
// Shared state encoding and sizing for the pin-level SRAM responder.
package sram_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_DRIVE,
    WR_ACTIVE,
    WR_COMMIT
  } state_t;

  localparam int MEM_DEPTH_DEF = 4096;
  localparam int MEM_AW        = $clog2(MEM_DEPTH_DEF);
  localparam int CNT_W         = 16;

endpackage

// File: rtl/sram_resp_sync.sv
// Control-pin synchronizer: STAGES flops, resets to 1 so active-low pins read as deasserted.
// Latency STAGES edges; no backpressure.
module sram_resp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sram_responder.sv
// Emulates an async 16-bit SRAM at its pins on block RAM; SRAM_RESPONDER_STATS_EN enables access counters.
// Latency: data_oe rises SYNC_STAGES+2 edges after CS/OE fall, drops SYNC_STAGES+1 after release; no backpressure.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_pins,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic              cs_n,
  input  logic              oe_n,
  input  logic              we_n,
  input  logic [AW-1:0]     bd_addr,
  output logic [DATA_W-1:0] bd_rdata,
  output logic              addr_err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  logic cs_s, oe_s, we_s;
  logic wr, rd;
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  sram_resp_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  sram_resp_sync #(.STAGES(SYNC_STAGES)) u_sync_oe (.clk(clk), .reset(reset), .d(oe_n), .q(oe_s));
  sram_resp_sync #(.STAGES(SYNC_STAGES)) u_sync_we (.clk(clk), .reset(reset), .d(we_n), .q(we_s));

  // A cycle with both WE and OE low is a write, so rd also requires WE high.
  assign wr = !cs_s && !we_s;
  assign rd = !cs_s && !oe_s && we_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> AW) == '0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      data_oe  <= 1'b0;
      data_out <= '0;
      addr_err <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          data_oe <= 1'b0;
          if (wr) begin
            state   <= WR_ACTIVE;
            addr_q  <= address_pins;
            wdata_q <= data_in;
          end else if (rd) begin
            state    <= RD_FETCH;
            addr_q   <= address_pins;
            addr_err <= !in_range(address_pins);
          end
        end
        RD_FETCH: begin
          if (!rd) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end else begin
            state    <= RD_DRIVE;
            data_oe  <= 1'b1;
            data_out <= in_range(addr_q) ? mem[addr_q[AW-1:0]] : '0;
          end
        end
        RD_DRIVE: begin
          if (!rd) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end else if (address_pins != addr_q) begin
            // Refetch while still driving the previous word.
            state    <= RD_FETCH;
            addr_q   <= address_pins;
            addr_err <= !in_range(address_pins);
          end
        end
        WR_ACTIVE: begin
          if (wr) begin
            addr_q  <= address_pins;
            wdata_q <= data_in;
          end else begin
            state    <= WR_COMMIT;
            addr_err <= !in_range(addr_q);
          end
        end
        WR_COMMIT: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == WR_COMMIT && in_range(addr_q)) begin
      mem[addr_q[AW-1:0]] <= wdata_q;
    end
    bd_rdata <= mem[bd_addr];
  end

`ifdef SRAM_RESPONDER_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state == IDLE && !wr && rd && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (state == WR_COMMIT && wr_cnt_q != '1)         wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Pin-level bench for sram_responder: table vectors, hand sequences and random ops vs a memory model.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam int S     = 2;
  localparam int DEPTH = 4096;

  logic        clk, reset;
  logic [17:0] address_pins;
  logic [15:0] data_in, data_out, bd_rdata;
  logic        data_oe, cs_n, oe_n, we_n, addr_err;
  logic [MEM_AW-1:0] bd_addr;
  logic [15:0] rd_count, wr_count;

  sram_responder #(.ADDR_W(18), .DATA_W(16), .MEM_DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .address_pins(address_pins), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n),
    .bd_addr(bd_addr), .bd_rdata(bd_rdata), .addr_err(addr_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  int nerr = 0, nchk = 0;
  int err_pulses = 0;
  int model_rd = 0, model_wr = 0;
  logic [15:0] mm [DEPTH];
  int written[$];

  always #5 clk = ~clk;
  always @(negedge clk) if (addr_err === 1'b1) err_pulses++;

  typedef enum {OP_WR, OP_WROE, OP_RD, OP_BD} op_e;
  typedef struct {
    op_e         op;
    logic [17:0] addr;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [9];

  function automatic int exp_cnt(input int v);
`ifdef SRAM_RESPONDER_STATS_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    model_rd = 0;
    model_wr = 0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input bit oe_too, input string tag);
    int e0;
    bit oe_seen;
    e0 = err_pulses;
    oe_seen = 0;
    address_pins = a; data_in = d; cs_n = 1'b0; we_n = 1'b0; oe_n = !oe_too;
    repeat (8) begin tick(); if (data_oe) oe_seen = 1; end
    cs_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    repeat (8) begin tick(); if (data_oe) oe_seen = 1; end
    check({tag, "_oe_quiet"}, 32'(oe_seen), 32'd0);
    check({tag, "_addr_err"}, 32'(err_pulses - e0), (a >= DEPTH) ? 32'd1 : 32'd0);
    if (a < DEPTH) begin
      mm[a[11:0]] = d;
      written.push_back(int'(a));
    end
    model_wr++;
  endtask

  task automatic do_read(input logic [17:0] a, input logic [15:0] exp, input string tag);
    int e0, n;
    e0 = err_pulses;
    address_pins = a; cs_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!data_oe && n < 20);
    check({tag, "_oe_latency"}, 32'(n), 32'(S + 2));
    check({tag, "_data"}, 32'(data_out), 32'(exp));
    cs_n = 1'b1; oe_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (data_oe && n < 20);
    check({tag, "_release_latency"}, 32'(n), 32'(S + 1));
    repeat (3) tick();
    check({tag, "_addr_err"}, 32'(err_pulses - e0), (a >= DEPTH) ? 32'd1 : 32'd0);
    model_rd++;
  endtask

  task automatic do_bd(input logic [11:0] a, input logic [15:0] exp, input string tag);
    bd_addr = a;
    tick();
    tick();
    check({tag, "_bd"}, 32'(bd_rdata), 32'(exp));
  endtask

  initial begin
    logic [17:0] a;
    logic [15:0] d;
    int r, n;
    bit dropped;

    clk = 1'b0; reset = 1'b1; cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    address_pins = '0; data_in = '0; bd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_data_oe", 32'(data_oe), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_addr_err", 32'(addr_err), 32'd0);
    check("reset_rd_count", 32'(rd_count), 32'd0);
    check("reset_wr_count", 32'(wr_count), 32'd0);

    tbl[0] = '{OP_WR,   18'h00010, 16'hBEEF, 16'h0000};
    tbl[1] = '{OP_RD,   18'h00010, 16'h0000, 16'hBEEF};
    tbl[2] = '{OP_BD,   18'h00010, 16'h0000, 16'hBEEF};
    tbl[3] = '{OP_WROE, 18'h00005, 16'h1234, 16'h0000};
    tbl[4] = '{OP_BD,   18'h00005, 16'h0000, 16'h1234};
    tbl[5] = '{OP_WR,   18'h00FFF, 16'h5A5A, 16'h0000};
    tbl[6] = '{OP_WR,   18'h3FFFF, 16'hDEAD, 16'h0000};
    tbl[7] = '{OP_BD,   18'h00FFF, 16'h0000, 16'h5A5A};
    tbl[8] = '{OP_RD,   18'h3FFFF, 16'h0000, 16'h0000};

    for (int i = 0; i < 9; i++) begin
      case (tbl[i].op)
        OP_WR:   do_write(tbl[i].addr, tbl[i].dat, 1'b0, $sformatf("tbl%0d_wr", i));
        OP_WROE: do_write(tbl[i].addr, tbl[i].dat, 1'b1, $sformatf("tbl%0d_wroe", i));
        OP_RD:   do_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rd", i));
        default: do_bd(tbl[i].addr[11:0], tbl[i].exp, $sformatf("tbl%0d", i));
      endcase
    end

    // Address stepping under a continuous OE.
    for (int k = 0; k < 4; k++) do_write(18'(k), 16'(k + 1), 1'b0, "step_wr");
    address_pins = 18'd0; cs_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!data_oe && n < 20);
    check("step_first_data", 32'(data_out), 32'd1);
    dropped = 0;
    for (int k = 1; k < 4; k++) begin
      address_pins = 18'(k);
      repeat (6) begin tick(); if (!data_oe) dropped = 1; end
      check($sformatf("step_data_%0d", k), 32'(data_out), 32'(k + 1));
    end
    check("step_oe_held", 32'(dropped), 32'd0);
    cs_n = 1'b1; oe_n = 1'b1;
    repeat (6) tick();
    model_rd++;
    check("step_wr_count", 32'(wr_count), 32'(exp_cnt(model_wr)));
    check("step_rd_count", 32'(rd_count), 32'(exp_cnt(model_rd)));

    // Reset while a write is still active must discard it.
    do_write(18'h00007, 16'h0707, 1'b0, "pre7_wr");
    address_pins = 18'h00007; data_in = 16'hAAAA; cs_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    repeat (S + 3) tick();
    reset = 1'b1; cs_n = 1'b1; we_n = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_rd = 0; model_wr = 0;
    tick();
    check("midrst_data_oe", 32'(data_oe), 32'd0);
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    repeat (8) tick();
    do_bd(12'h007, 16'h0707, "midrst_mem7");

    // WE low with CS high is ignored.
    do_write(18'h00008, 16'h0808, 1'b0, "pre8_wr");
    address_pins = 18'h00007; data_in = 16'hBBBB; cs_n = 1'b1; we_n = 1'b0;
    repeat (10) tick();
    we_n = 1'b1;
    repeat (5) tick();
    do_bd(12'h007, 16'h0707, "cshigh_mem7");
    check("cshigh_wr_count", 32'(wr_count), 32'(exp_cnt(model_wr)));

    // Random traffic against the memory model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4 || written.size() == 0) begin
        a = 18'($urandom_range(0, DEPTH - 1));
        d = 16'($urandom);
        do_write(a, d, r == 4, "rnd_wr");
      end else if (r <= 7) begin
        a = 18'(written[$urandom_range(0, written.size() - 1)]);
        do_read(a, mm[a[11:0]], "rnd_rd");
      end else if (r == 8) begin
        a = 18'(DEPTH + $urandom_range(0, 262143 - DEPTH));
        if (i % 2 == 0) do_write(a, 16'($urandom), 1'b0, "rnd_oor_wr");
        else            do_read(a, 16'h0000, "rnd_oor_rd");
      end else begin
        a = 18'(written[$urandom_range(0, written.size() - 1)]);
        do_bd(a[11:0], mm[a[11:0]], "rnd");
      end
    end
    check("rnd_wr_count", 32'(wr_count), 32'(exp_cnt(model_wr)));
    check("rnd_rd_count", 32'(rd_count), 32'(exp_cnt(model_rd)));

    // Counters after a clean reset: three writes, two reads.
    do_reset();
    do_write(18'h00020, 16'h1111, 1'b0, "cnt_wr0");
    do_write(18'h00021, 16'h2222, 1'b0, "cnt_wr1");
    do_write(18'h00022, 16'h3333, 1'b0, "cnt_wr2");
    do_read(18'h00020, 16'h1111, "cnt_rd0");
    do_read(18'h00022, 16'h3333, "cnt_rd1");
    check("final_wr_count", 32'(wr_count), 32'(exp_cnt(3)));
    check("final_rd_count", 32'(rd_count), 32'(exp_cnt(2)));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
